// File: rtl/riscv_pkg.sv
// Shared types for the fetch/LSU memory arbiter.
package riscv_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic ARB_PORT_IMEM = 1'b0;
    localparam logic ARB_PORT_DMEM = 1'b1;

endpackage

// File: rtl/riscv_arb_pick.sv
// Tie-break between fetch (port 0) and LSU (port 1).
// Define ARB_ROUND_ROBIN_EN for alternating ties; otherwise the LSU always wins.
module riscv_arb_pick
    import riscv_pkg::*;
(
    input  logic p0_req,
    input  logic p1_req,
    input  logic last_grant,
    output logic winner
);

    always_comb begin
        winner = ARB_PORT_IMEM;
        if (p1_req && !p0_req) begin
            winner = ARB_PORT_DMEM;
        end else if (p0_req && p1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            winner = ~last_grant;
`else
            // Always resolves to the LSU; last_grant only keeps the port read.
            winner = last_grant | ARB_PORT_DMEM;
`endif
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Two-port (fetch/LSU) arbiter onto a single memory port with a no-ack watchdog.
// Tie policy selected by ARB_ROUND_ROBIN_EN (see riscv_arb_pick).
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        p0_req_i,
    input  logic        p0_we_i,
    input  logic [3:0]  p0_be_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wd_i,
    output logic [31:0] p0_rd_o,
    output logic        p0_ready_o,
    input  logic        p1_req_i,
    input  logic        p1_we_i,
    input  logic [3:0]  p1_be_i,
    input  logic [31:0] p1_addr_i,
    input  logic [31:0] p1_wd_i,
    output logic [31:0] p1_rd_o,
    output logic        p1_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i,
    output logic        bus_err_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t    state, state_nxt;
    logic          grant, last_grant, winner, cnt_last;
    logic [CW-1:0] cnt;
    logic [31:0]   cpl_rd;

    riscv_arb_pick u_pick (
        .p0_req     (p0_req_i),
        .p1_req     (p1_req_i),
        .last_grant (last_grant),
        .winner     (winner)
    );

    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ARB_IDLE;
            grant      <= ARB_PORT_IMEM;
            last_grant <= ARB_PORT_DMEM;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ARB_IDLE: begin
                    if (p0_req_i || p1_req_i) begin
                        grant <= winner;
                        cnt   <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (mem_ready_i || cnt_last) last_grant <= grant;
                    else                         cnt        <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_be_o   = '0;
        mem_addr_o = '0;
        mem_wd_o   = '0;
        p0_ready_o = 1'b0;
        p1_ready_o = 1'b0;
        p0_rd_o    = '0;
        p1_rd_o    = '0;
        bus_err_o  = 1'b0;
        cpl_rd     = '0;
        case (state)
            ARB_IDLE: begin
                if (p0_req_i || p1_req_i) state_nxt = ARB_BUSY;
            end
            ARB_BUSY: begin
                mem_req_o  = 1'b1;
                mem_we_o   = grant ? p1_we_i   : p0_we_i;
                mem_be_o   = grant ? p1_be_i   : p0_be_i;
                mem_addr_o = grant ? p1_addr_i : p0_addr_i;
                mem_wd_o   = grant ? p1_wd_i   : p0_wd_i;
                // An ack on the last watchdog cycle still counts as a normal completion.
                if (mem_ready_i || cnt_last) begin
                    state_nxt = ARB_IDLE;
                    bus_err_o = !mem_ready_i;
                    cpl_rd    = mem_ready_i ? mem_rd_i : '0;
                    if (grant) begin
                        p1_ready_o = 1'b1;
                        p1_rd_o    = cpl_rd;
                    end else begin
                        p0_ready_o = 1'b1;
                        p0_rd_o    = cpl_rd;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter (TIMEOUT=4); expected completions are
// queued as stimulus is driven and retired by a negedge monitor.
module tb_riscv_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [3:0]  p0_be, p1_be;
    logic [31:0] p0_addr, p0_wd, p1_addr, p1_wd;
    logic [31:0] p0_rd, p1_rd;
    logic        p0_ready, p1_ready;
    logic        mem_req, mem_we, mem_ready, bus_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    typedef struct {
        logic        port;
        logic [31:0] rd;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cpl_cnt = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .p0_req_i    (p0_req),
        .p0_we_i     (p0_we),
        .p0_be_i     (p0_be),
        .p0_addr_i   (p0_addr),
        .p0_wd_i     (p0_wd),
        .p0_rd_o     (p0_rd),
        .p0_ready_o  (p0_ready),
        .p1_req_i    (p1_req),
        .p1_we_i     (p1_we),
        .p1_be_i     (p1_be),
        .p1_addr_i   (p1_addr),
        .p1_wd_i     (p1_wd),
        .p1_rd_o     (p1_rd),
        .p1_ready_o  (p1_ready),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_be_o    (mem_be),
        .mem_addr_o  (mem_addr),
        .mem_wd_o    (mem_wd),
        .mem_rd_i    (mem_rd),
        .mem_ready_i (mem_ready),
        .bus_err_o   (bus_err)
    );

    // Retire one scoreboard entry per completion pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (p0_ready && p1_ready) begin
                checks++; errors++;
                $display("FAIL dual_ready: both ready pulses asserted");
            end else if (p0_ready || p1_ready) begin
                exp_t e;
                logic        gp;
                logic [31:0] grd;
                checks++;
                cpl_cnt++;
                gp  = p1_ready;
                grd = p1_ready ? p1_rd : p0_rd;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: completion port %0d with empty queue", gp);
                end else begin
                    e = sb.pop_front();
                    if (gp !== e.port || grd !== e.rd || bus_err !== e.err
                        || mem_addr !== e.addr || mem_req !== 1'b1
                        || (gp ? p0_rd : p1_rd) !== 32'h0) begin
                        errors++;
                        $display("FAIL sb_cpl: got port %0d rd %h err %b addr %h req %b, want port %0d rd %h err %b addr %h",
                                 gp, grd, bus_err, mem_addr, mem_req, e.port, e.rd, e.err, e.addr);
                    end
                end
            end else if (bus_err) begin
                checks++; errors++;
                $display("FAIL err_alone: bus_err without ready");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_be = 4'hF; p0_addr = 0; p0_wd = 0;
        p1_req = 0; p1_we = 0; p1_be = 4'hF; p1_addr = 0; p1_wd = 0;
        mem_ready = 0; mem_rd = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) tick();
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wd, p0_ready, p1_ready, p0_rd, p1_rd, bus_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: req %b ready %b/%b err %b addr %h, want all 0",
                     mem_req, p0_ready, p1_ready, bus_err, mem_addr);
        end
        rst_n = 1;
        tick();
    endtask

    task automatic test_read();
        p1_req = 1; p1_addr = 32'h100; p1_we = 0;
        sb.push_back('{port: 1'b1, rd: 32'hDEADBEEF, err: 1'b0, addr: 32'h100});
        #1;
        checks++;
        if (mem_req !== 1'b0 || p1_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: mem_req %b p1_ready %b, want 0 0", mem_req, p1_ready);
        end
        tick();
        mem_ready = 1; mem_rd = 32'hDEADBEEF;
        #1;
        checks++;
        if (p1_ready !== 1'b1 || p0_ready !== 1'b0 || p1_rd !== 32'hDEADBEEF || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL read_cpl: p1_ready %b p0_ready %b p1_rd %h we %b, want 1 0 deadbeef 0",
                     p1_ready, p0_ready, p1_rd, mem_we);
        end
        tick();
        p1_req = 0; mem_ready = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || p1_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_dead: mem_req %b p1_ready %b, want 0 0", mem_req, p1_ready);
        end
    endtask

    task automatic test_write();
        int c0;
        c0 = cpl_cnt;
        tick();
        p1_req = 1; p1_we = 1; p1_be = 4'b0011; p1_addr = 32'h204; p1_wd = 32'h0000_1234;
        mem_rd = 32'hA5A5_A5A5;
        sb.push_back('{port: 1'b1, rd: 32'hA5A5_A5A5, err: 1'b0, addr: 32'h204});
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) mem_ready = 1;
            #1;
            checks++;
            if (mem_req !== 1 || mem_we !== 1 || mem_be !== 4'b0011 || mem_addr !== 32'h204
                || mem_wd !== 32'h1234 || p1_ready !== (k == 2)) begin
                errors++;
                $display("FAIL write_hold[%0d]: req %b we %b be %b addr %h wd %h rdy %b",
                         k, mem_req, mem_we, mem_be, mem_addr, mem_wd, p1_ready);
            end
        end
        tick();
        p1_req = 0; p1_we = 0; p1_be = 4'hF; mem_ready = 0;
        repeat (2) tick();
        checks++;
        if (cpl_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL write_count: %0d completions, want 1", cpl_cnt - c0);
        end
    endtask

    task automatic test_back_to_back();
        int j;
        rst_n = 0;
        tick();
        rst_n = 1;
        p0_req = 1; p0_addr = 32'h400;
        p1_req = 1; p1_addr = 32'h800;
        mem_ready = 1;
        j = 0;
        for (int k = 0; k < 8; k++) begin
            mem_rd = 32'hC000_0000 + k;
            if (k % 2 == 1) begin
`ifdef ARB_ROUND_ROBIN_EN
                logic p = (j % 2 == 1);
`else
                logic p = 1'b1;
`endif
                sb.push_back('{port: p, rd: 32'hC000_0000 + k, err: 1'b0,
                               addr: p ? 32'h800 : 32'h400});
                j++;
            end
            tick();
        end
        p0_req = 0; p1_req = 0; mem_ready = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: mem_req %b, want 0", mem_req);
        end
        tick();
    endtask

    task automatic test_timeout();
        p0_req = 1; p0_addr = 32'h300;
        mem_rd = 32'hFFFF_FFFF;
        sb.push_back('{port: 1'b0, rd: 32'h0, err: 1'b1, addr: 32'h300});
        for (int k = 1; k <= TO; k++) begin
            tick();
            #1;
            checks++;
            if (mem_req !== 1 || bus_err !== (k == TO) || p0_ready !== (k == TO)) begin
                errors++;
                $display("FAIL timeout[%0d]: req %b err %b rdy %b, want 1 %b %b",
                         k, mem_req, bus_err, p0_ready, k == TO, k == TO);
            end
        end
        tick();
        p0_req = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: req %b err %b, want 0 0", mem_req, bus_err);
        end
        tick();
    endtask

    task automatic test_coincident();
        p0_req = 1; p0_addr = 32'h500;
        sb.push_back('{port: 1'b0, rd: 32'h600D_F00D, err: 1'b0, addr: 32'h500});
        repeat (TO) tick();
        mem_ready = 1; mem_rd = 32'h600D_F00D;
        #1;
        checks++;
        if (bus_err !== 1'b0 || p0_ready !== 1'b1 || p0_rd !== 32'h600D_F00D) begin
            errors++;
            $display("FAIL coincident: err %b rdy %b rd %h, want 0 1 600df00d", bus_err, p0_ready, p0_rd);
        end
        tick();
        p0_req = 0; mem_ready = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        p1_req = 1; p1_addr = 32'h900;
        tick();
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy: mem_req %b, want 1", mem_req);
        end
        rst_n = 0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || p1_ready !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: req %b rdy %b err %b, want 0 0 0", mem_req, p1_ready, bus_err);
        end
        tick();
        p0_req = 1; p0_addr = 32'hA00;
        rst_n = 1;
        tick();
        mem_ready = 1; mem_rd = 32'h1357_9BDF;
`ifdef ARB_ROUND_ROBIN_EN
        sb.push_back('{port: 1'b0, rd: 32'h1357_9BDF, err: 1'b0, addr: 32'hA00});
`else
        sb.push_back('{port: 1'b1, rd: 32'h1357_9BDF, err: 1'b0, addr: 32'h900});
`endif
        tick();
        p0_req = 0; p1_req = 0; mem_ready = 0;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_timeout();
        test_coincident();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected completions never seen, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
